layer_seq_ctrl: RTL and testbench

LAYER_SEQ_CTRL -- requirements
Module: layer_seq_ctrl

---
 rtl/layer_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_layer_seq_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_seq_ctrl.sv
// Sequencer for one fully-connected layer pass: walks neuron j and input i,
// issuing MAC and activation handshakes and writing one result per neuron.
module layer_seq_ctrl #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mac_done,
    input  logic          act_done,
    output logic          busy,
    output logic          done,
    output logic          acc_clr,
    output logic          mac_go,
    output logic          act_go,
    output logic          out_we,
    output logic [AW-1:0] in_addr,
    output logic [AW-1:0] w_addr,
    output logic [AW-1:0] out_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_MAC_ISSUE,
        S_MAC_WAIT,
        S_ACT_ISSUE,
        S_ACT_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] I_LAST = AW'(N_IN - 1);
    localparam logic [AW-1:0] J_LAST = AW'(N_OUT - 1);
    localparam logic [AW-1:0] N_IN_W = AW'(N_IN);

    state_t        state_q, state_d;
    logic [AW-1:0] i_q, i_d;
    logic [AW-1:0] j_q, j_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          acc_clr_q, acc_clr_d;
    logic          mac_go_q, mac_go_d;
    logic          act_go_q, act_go_d;
    logic          out_we_q, out_we_d;
    logic [AW-1:0] in_addr_q, in_addr_d;
    logic [AW-1:0] w_addr_q, w_addr_d;
    logic [AW-1:0] out_addr_q, out_addr_d;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_CLR;
                end
            end
            S_CLR:       state_d = S_MAC_ISSUE;
            S_MAC_ISSUE: state_d = S_MAC_WAIT;
            S_MAC_WAIT: begin
                if (mac_done) begin
                    if (i_q == I_LAST) begin
                        i_d     = '0;
                        state_d = S_ACT_ISSUE;
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = S_MAC_ISSUE;
                    end
                end
            end
            S_ACT_ISSUE: state_d = S_ACT_WAIT;
            S_ACT_WAIT: begin
                if (act_done) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (j_q == J_LAST) begin
                    state_d = S_DONE;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = S_CLR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pulse lines
    // up with the cycle in which the FSM actually sits in that state.
    always_comb begin
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        acc_clr_d  = (state_d == S_CLR);
        mac_go_d   = (state_d == S_MAC_ISSUE);
        act_go_d   = (state_d == S_ACT_ISSUE);
        out_we_d   = (state_d == S_WRITE);
        in_addr_d  = in_addr_q;
        w_addr_d   = w_addr_q;
        out_addr_d = out_addr_q;

        if (state_d == S_MAC_ISSUE) begin
            in_addr_d = i_d;
            w_addr_d  = j_d * N_IN_W + i_d;
        end
        if (state_d == S_WRITE) begin
            out_addr_d = j_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            acc_clr_q  <= 1'b0;
            mac_go_q   <= 1'b0;
            act_go_q   <= 1'b0;
            out_we_q   <= 1'b0;
            in_addr_q  <= '0;
            w_addr_q   <= '0;
            out_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            acc_clr_q  <= acc_clr_d;
            mac_go_q   <= mac_go_d;
            act_go_q   <= act_go_d;
            out_we_q   <= out_we_d;
            in_addr_q  <= in_addr_d;
            w_addr_q   <= w_addr_d;
            out_addr_q <= out_addr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign acc_clr  = acc_clr_q;
    assign mac_go   = mac_go_q;
    assign act_go   = act_go_q;
    assign out_we   = out_we_q;
    assign in_addr  = in_addr_q;
    assign w_addr   = w_addr_q;
    assign out_addr = out_addr_q;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Scoreboard bench for layer_seq_ctrl: a pass model queues the expected pulse
// sequence on each accepted start; a negedge monitor pops and compares.
module tb_layer_seq_ctrl;

    localparam int AW = 8;
    localparam int NI = 4;
    localparam int NO = 3;
    localparam int PASS_CYCLES = NO * (2 * NI + 4) + 1;

    localparam logic [2:0] K_CLR  = 3'd0;
    localparam logic [2:0] K_MAC  = 3'd1;
    localparam logic [2:0] K_ACT  = 3'd2;
    localparam logic [2:0] K_WE   = 3'd3;
    localparam logic [2:0] K_DONE = 3'd4;
    localparam logic [2:0] K_NONE = 3'd7;

    logic clk = 1'b0;
    logic reset;
    logic start, mac_done, act_done;
    logic busy, done, acc_clr, mac_go, act_go, out_we;
    logic [AW-1:0] in_addr, w_addr, out_addr;

    logic start1, mac_done1, act_done1;
    logic busy1, done1, acc_clr1, mac_go1, act_go1, out_we1;
    logic [AW-1:0] in_addr1, w_addr1, out_addr1;

    always #5 clk = ~clk;

    layer_seq_ctrl #(.N_IN(NI), .N_OUT(NO), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .mac_done(mac_done), .act_done(act_done),
        .busy(busy), .done(done), .acc_clr(acc_clr), .mac_go(mac_go), .act_go(act_go),
        .out_we(out_we), .in_addr(in_addr), .w_addr(w_addr), .out_addr(out_addr)
    );

    layer_seq_ctrl #(.N_IN(1), .N_OUT(1), .AW(AW)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .mac_done(mac_done1), .act_done(act_done1),
        .busy(busy1), .done(done1), .acc_clr(acc_clr1), .mac_go(mac_go1), .act_go(act_go1),
        .out_we(out_we1), .in_addr(in_addr1), .w_addr(w_addr1), .out_addr(out_addr1)
    );

    typedef struct packed {
        logic [2:0]    kind;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    bit  mon_en = 1'b0;
    bit  done_cycle = 1'b0;
    bit  waiting_mac = 1'b0;
    bit  timing_on = 1'b0;
    logic [AW-1:0] hold_in, hold_w;
    int  mon_cyc = 0;
    int  pass_t0 = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: one pass = for each neuron, clear, N_IN MACs, activate, write; then done.
    task automatic push_pass();
        ev_t e;
        for (int j = 0; j < NO; j++) begin
            e.kind = K_CLR; e.a = AW'(j); e.b = '0; exp_q.push_back(e);
            for (int i = 0; i < NI; i++) begin
                e.kind = K_MAC; e.a = AW'(i); e.b = AW'(j * NI + i); exp_q.push_back(e);
            end
            e.kind = K_ACT; e.a = '0; e.b = '0; exp_q.push_back(e);
            e.kind = K_WE; e.a = AW'(j); e.b = '0; exp_q.push_back(e);
        end
        e.kind = K_DONE; e.a = '0; e.b = '0; exp_q.push_back(e);
    endtask

    function automatic bit model_idle();
        return (exp_q.size() == 0) && !done_cycle;
    endfunction

    int         npulse;
    logic [2:0] got_kind;
    ev_t        cur;

    always @(negedge clk) begin
        done_cycle = 1'b0;
        if (mon_en && !reset) begin
            mon_cyc++;
            npulse = int'(acc_clr) + int'(mac_go) + int'(act_go) + int'(out_we) + int'(done);
            got_kind = acc_clr ? K_CLR : mac_go ? K_MAC : act_go ? K_ACT : out_we ? K_WE : K_DONE;
            check("busy", 32'(busy), 32'(exp_q.size() != 0));
            if (npulse > 1) begin
                check("one_pulse_at_a_time", 32'(npulse), 32'd1);
            end else if (npulse == 1) begin
                if (exp_q.size() == 0) begin
                    check("pulse_with_nothing_expected", 32'(got_kind), 32'(K_NONE));
                end else begin
                    cur = exp_q.pop_front();
                    check("pulse_kind", 32'(got_kind), 32'(cur.kind));
                    waiting_mac = (cur.kind == K_MAC);
                    if (cur.kind == K_MAC) begin
                        check("mac_in_addr", 32'(in_addr), 32'(cur.a));
                        check("mac_w_addr", 32'(w_addr), 32'(cur.b));
                        hold_in = cur.a;
                        hold_w  = cur.b;
                    end
                    if (cur.kind == K_WE) check("out_addr", 32'(out_addr), 32'(cur.a));
                    if (cur.kind == K_CLR && cur.a == '0) pass_t0 = mon_cyc;
                    if (cur.kind == K_DONE) begin
                        done_cycle = 1'b1;
                        if (timing_on) check("pass_cycles", 32'(mon_cyc - pass_t0 + 1), 32'(PASS_CYCLES));
                    end
                end
            end else if (waiting_mac) begin
                check("wait_in_addr_hold", 32'(in_addr), 32'(hold_in));
                check("wait_w_addr_hold", 32'(w_addr), 32'(hold_w));
            end
        end
    end

    // Environment plus stimulus for one pass. md/ad: handshake delay (<0 = random).
    task automatic run_pass(input int md, input int ad, input bit spur, input bit rstart, input int abort_act);
        int mpend = 0;
        int apend = 0;
        int acts = 0;
        int cyc = 0;
        bit abort_now = 1'b0;
        bit started = 1'b0;
        bit finished = 1'b0;
        timing_on = (md == 0 && ad == 0);
        while (cyc < 3000 && !finished) begin
            @(negedge clk); #1;
            cyc++;
            if (abort_now) begin
                reset = 1'b1; start = 1'b0; mac_done = 1'b0; act_done = 1'b0;
                #1;
                check("abort_pulses_zero", 32'({busy, done, acc_clr, mac_go, act_go, out_we}), 32'd0);
                check("abort_addrs_zero", 32'({in_addr, w_addr, out_addr}), 32'd0);
                exp_q.delete();
                waiting_mac = 1'b0;
                @(negedge clk); #1;
                reset = 1'b0;
                return;
            end
            start = 1'b0; mac_done = 1'b0; act_done = 1'b0;
            if (mpend > 0) begin mpend--; if (mpend == 0) mac_done = 1'b1; end
            if (apend > 0) begin apend--; if (apend == 0) act_done = 1'b1; end
            if (mac_go) mpend = (md < 0 ? int'($urandom_range(0, 4)) : md) + 1;
            if (act_go) begin
                apend = (ad < 0 ? int'($urandom_range(0, 4)) : ad) + 1;
                acts++;
                if (acts - 1 == abort_act) abort_now = 1'b1;
            end
            if (spur) begin
                if (!mac_done) mac_done = ($urandom_range(0, 2) == 0);
                if (!act_done) act_done = ($urandom_range(0, 2) == 0);
            end
            if (!started) begin
                start = 1'b1;
                started = 1'b1;
            end else if (rstart) begin
                start = ($urandom_range(0, 3) == 0);
            end
            if (start && model_idle()) push_pass();
            if (model_idle()) finished = 1'b1;
        end
        check("pass_finished", 32'(finished), 32'd1);
    endtask

    logic [5:0] tr1 [9];

    initial begin
        reset = 1'b1; start = 1'b0; mac_done = 1'b0; act_done = 1'b0;
        start1 = 1'b0; mac_done1 = 1'b0; act_done1 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pulses", 32'({busy, done, acc_clr, mac_go, act_go, out_we}), 32'd0);
        check("reset_addrs", 32'({in_addr, w_addr, out_addr}), 32'd0);
        check("reset_n1", 32'({busy1, done1, acc_clr1, mac_go1, act_go1, out_we1}), 32'd0);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        run_pass(0, 0, 1'b0, 1'b0, -1);     // clean, immediate handshakes
        run_pass(7, 0, 1'b0, 1'b0, -1);     // slow MAC
        run_pass(0, 0, 1'b1, 1'b1, -1);     // spurious handshakes and repeated start
        run_pass(0, 2, 1'b0, 1'b0, 1);      // reset in ACT_WAIT of neuron 1
        repeat (4) @(negedge clk);
        run_pass(0, 0, 1'b0, 1'b0, -1);
        for (int r = 0; r < 4; r++) run_pass(-1, -1, 1'b0, 1'b0, -1);

        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            mac_done = 1'($urandom_range(0, 1));
            act_done = 1'($urandom_range(0, 1));
        end
        @(negedge clk); #1;
        mac_done = 1'b0; act_done = 1'b0;
        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // N_IN=N_OUT=1 instance: busy,done,acc_clr,mac_go,act_go,out_we per cycle,
        // start held high so the IDLE cycle after done launches a second pass.
        tr1[0] = 6'b101000; tr1[1] = 6'b100100; tr1[2] = 6'b100000;
        tr1[3] = 6'b100010; tr1[4] = 6'b100000; tr1[5] = 6'b100001;
        tr1[6] = 6'b110000; tr1[7] = 6'b000000; tr1[8] = 6'b101000;
        mac_done1 = 1'b1; act_done1 = 1'b1;
        @(negedge clk); #1;
        start1 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("n1_trace_%0d", k),
                  32'({busy1, done1, acc_clr1, mac_go1, act_go1, out_we1, in_addr1, w_addr1, out_addr1}),
                  32'({tr1[k], {(3 * AW){1'b0}}}));
        end
        #1 start1 = 1'b0;
        repeat (10) @(negedge clk);
        check("n1_back_to_idle", 32'(busy1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
